// File: rtl/zap_shift_operand_stage_pkg.sv
// Shared types and constants for the shift operand stage: shifter op codes,
// the ARM shift-field encoding and the default op count.
package zap_shift_operand_stage_pkg;

  localparam int SHIFT_OPS = 5;
  localparam int SHTYPE_W  = $clog2(SHIFT_OPS);

  // Shifter op codes shared with zap_shift_shifter.
  localparam logic [SHTYPE_W-1:0] SH_LSL   = 3'd0;
  localparam logic [SHTYPE_W-1:0] SH_LSR   = 3'd1;
  localparam logic [SHTYPE_W-1:0] SH_ASR   = 3'd2;
  localparam logic [SHTYPE_W-1:0] SH_ROR   = 3'd3;
  localparam logic [SHTYPE_W-1:0] SH_ROR_1 = 3'd4;
  localparam logic [SHTYPE_W-1:0] SH_RRC   = 3'd5;
  localparam logic [SHTYPE_W-1:0] SH_RORI  = 3'd6;

  typedef enum logic [1:0] {
    ARM_LSL = 2'd0,
    ARM_LSR = 2'd1,
    ARM_ASR = 2'd2,
    ARM_ROR = 2'd3
  } arm_shift_t;

endpackage

// File: rtl/zap_shift_amount_decode.sv
// Combinational map from the ARM shift field to the shifter's {type, amount}.
// Zero latency; no flow control of its own.
module zap_shift_amount_decode
  import zap_shift_operand_stage_pkg::*;
(
  input  logic [1:0]          arm_type,
  input  logic [4:0]          shamt_imm,
  input  logic                shamt_is_reg,
  input  logic [7:0]          rs_low,
  output logic [SHTYPE_W-1:0] shift_type,
  output logic [7:0]          amount
);

  always_comb begin
    shift_type = SH_LSL;
    amount     = {3'b000, shamt_imm};
    if (shamt_is_reg) begin
      amount = rs_low;
      unique case (arm_shift_t'(arm_type))
        ARM_LSL: shift_type = SH_LSL;
        ARM_LSR: shift_type = SH_LSR;
        ARM_ASR: shift_type = SH_ASR;
        ARM_ROR: shift_type = SH_ROR;
      endcase
    end else begin
      // An immediate amount of 0 is the ARM encoding for #32 / RRX.
      unique case (arm_shift_t'(arm_type))
        ARM_LSL: shift_type = SH_LSL;
        ARM_LSR: begin
          shift_type = SH_LSR;
          if (shamt_imm == 5'd0) amount = 8'd32;
        end
        ARM_ASR: begin
          shift_type = SH_ASR;
          if (shamt_imm == 5'd0) amount = 8'd32;
        end
        ARM_ROR: begin
          if (shamt_imm == 5'd0) begin
            shift_type = SH_RRC;
            amount     = 8'd0;
          end else begin
            shift_type = SH_ROR_1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/zap_shift_operand_stage.sv
// Operand capture + shift decode in front of the barrel shifter.
// Latency 1 cycle (imm) / 2 cycles (reg shift); i_stall freezes all state, o_stall throttles issue.
module zap_shift_operand_stage
  import zap_shift_operand_stage_pkg::*;
#(
  parameter int SHIFT_OPS = zap_shift_operand_stage_pkg::SHIFT_OPS
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clear,
  input  logic                         i_stall,
  input  logic                         i_valid,
  input  logic [31:0]                  i_source,
  input  logic [31:0]                  i_rs_value,
  input  logic [4:0]                   i_shamt_imm,
  input  logic                         i_shamt_is_reg,
  input  logic [1:0]                   i_arm_type,
  input  logic                         i_carry,
  output logic                         o_stall,
  output logic                         o_valid,
  output logic [31:0]                  o_source,
  output logic [7:0]                   o_amount,
  output logic                         o_carry,
  output logic [$clog2(SHIFT_OPS)-1:0] o_shift_type
);

  localparam int TW = $clog2(SHIFT_OPS);

  typedef enum logic {
    IDLE     = 1'b0,
    REG_WAIT = 1'b1
  } state_t;

  state_t              state;
  logic [SHTYPE_W-1:0] dec_type;
  logic [7:0]          dec_amount;
  logic                unused_rs_hi;

  // Only Rs[7:0] carries a shift amount.
  assign unused_rs_hi = ^i_rs_value[31:8];

  zap_shift_amount_decode u_decode (
    .arm_type     (i_arm_type),
    .shamt_imm    (i_shamt_imm),
    .shamt_is_reg (i_shamt_is_reg),
    .rs_low       (i_rs_value[7:0]),
    .shift_type   (dec_type),
    .amount       (dec_amount)
  );

  always_ff @(posedge i_clk) begin
    // Reset and flush have identical effect, so one branch serves both.
    if (i_reset || i_clear) begin
      state        <= IDLE;
      o_valid      <= 1'b0;
      o_stall      <= 1'b0;
      o_source     <= 32'd0;
      o_amount     <= 8'd0;
      o_carry      <= 1'b0;
      o_shift_type <= TW'(SH_LSL);
    end else if (!i_stall) begin
      unique case (state)
        IDLE: begin
          o_valid <= 1'b0;
          o_stall <= 1'b0;
          if (i_valid) begin
            o_source     <= i_source;
            o_amount     <= dec_amount;
            o_carry      <= i_carry;
            o_shift_type <= TW'(dec_type);
            if (i_shamt_is_reg) begin
              // Bundle is already parked in the output registers; release it next cycle.
              state   <= REG_WAIT;
              o_stall <= 1'b1;
            end else begin
              o_valid <= 1'b1;
            end
          end
        end
        REG_WAIT: begin
          state   <= IDLE;
          o_valid <= 1'b1;
          o_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_shift_operand_stage.sv
// Directed bench for zap_shift_operand_stage with a queue scoreboard and negedge monitor.
module tb_zap_shift_operand_stage;
  import zap_shift_operand_stage_pkg::*;

  typedef struct packed {
    logic [2:0]  t;
    logic [7:0]  amt;
    logic        c;
    logic [31:0] src;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset, i_clear, i_stall, i_valid;
  logic [31:0] i_source, i_rs_value;
  logic [4:0]  i_shamt_imm;
  logic        i_shamt_is_reg;
  logic [1:0]  i_arm_type;
  logic        i_carry;
  logic        o_stall, o_valid, o_carry;
  logic [31:0] o_source;
  logic [7:0]  o_amount;
  logic [2:0]  o_shift_type;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 i_clk = ~i_clk;

  zap_shift_operand_stage #(.SHIFT_OPS(5)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (i_clear),
    .i_stall        (i_stall),
    .i_valid        (i_valid),
    .i_source       (i_source),
    .i_rs_value     (i_rs_value),
    .i_shamt_imm    (i_shamt_imm),
    .i_shamt_is_reg (i_shamt_is_reg),
    .i_arm_type     (i_arm_type),
    .i_carry        (i_carry),
    .o_stall        (o_stall),
    .o_valid        (o_valid),
    .o_source       (o_source),
    .o_amount       (o_amount),
    .o_carry        (o_carry),
    .o_shift_type   (o_shift_type)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A transfer happens on a rising edge where o_valid=1 and downstream is not stalled.
  always @(negedge i_clk) begin
    if (!i_reset && !i_clear && o_valid && !i_stall) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got src 0x%0h amt 0x%0h, expected no output", o_source, o_amount);
      end else begin
        mon_e = sb.pop_front();
        check("xfer{type,amt,c,src}", {20'd0, o_shift_type, o_amount, o_carry, o_source}, {20'd0, mon_e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d entries outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic isreg, input logic [1:0] at, input logic [4:0] sh,
                       input logic [31:0] src, input logic [31:0] rs, input logic c);
    i_valid        = v;
    i_shamt_is_reg = isreg;
    i_arm_type     = at;
    i_shamt_imm    = sh;
    i_source       = src;
    i_rs_value     = rs;
    i_carry        = c;
  endtask

  task automatic issue_imm(input logic [1:0] at, input logic [4:0] sh, input logic [31:0] src,
                           input logic c, input logic [2:0] et, input logic [7:0] ea);
    drive(1'b1, 1'b0, at, sh, src, 32'hDEAD_BEEF, c);
    sb.push_back('{t: et, amt: ea, c: c, src: src});
    tick();
    i_valid = 1'b0;
  endtask

  task automatic issue_reg(input logic [1:0] at, input logic [31:0] rs, input logic [31:0] src,
                           input logic c, input logic [2:0] et, input logic [7:0] ea);
    drive(1'b1, 1'b1, at, 5'd7, src, rs, c);
    sb.push_back('{t: et, amt: ea, c: c, src: src});
    tick();
    check("reg_wait_stall", 64'(o_stall), 64'd1);
    check("reg_wait_novalid", 64'(o_valid), 64'd0);
    tick();
    check("reg_done_stall", 64'(o_stall), 64'd0);
    check("reg_done_valid", 64'(o_valid), 64'd1);
    i_valid = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_clear = 1'b0;
    i_stall = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    i_reset = 1'b0;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_type", 64'(o_shift_type), 64'(SH_LSL));
    check("rst_amount", 64'(o_amount), 64'd0);
    check("rst_source", 64'(o_source), 64'd0);
    check("rst_carry", 64'(o_carry), 64'd0);

    // Immediate decodes, back to back.
    issue_imm(2'd1, 5'd0,  32'h8000_0001, 1'b0, SH_LSR,   8'd32);
    issue_imm(2'd3, 5'd0,  32'h1234_5678, 1'b1, SH_RRC,   8'd0);
    issue_imm(2'd3, 5'd4,  32'hF000_000F, 1'b0, SH_ROR_1, 8'd4);
    issue_imm(2'd2, 5'd0,  32'h8765_4321, 1'b1, SH_ASR,   8'd32);
    issue_imm(2'd0, 5'd0,  32'h0000_00FF, 1'b1, SH_LSL,   8'd0);
    issue_imm(2'd0, 5'd31, 32'hAAAA_5555, 1'b0, SH_LSL,   8'd31);
    issue_imm(2'd1, 5'd17, 32'h0F0F_0F0F, 1'b1, SH_LSR,   8'd17);
    issue_imm(2'd2, 5'd1,  32'hFFFF_0000, 1'b0, SH_ASR,   8'd1);
    tick();
    check("idle_novalid", 64'(o_valid), 64'd0);

    // Register-specified shifts; an imm op follows straight after the first.
    issue_reg(2'd2, 32'h0000_0121, 32'hCAFE_F00D, 1'b1, SH_ASR, 8'h21);
    issue_imm(2'd2, 5'd3, 32'h1111_2222, 1'b0, SH_ASR, 8'd3);
    issue_reg(2'd3, 32'hFFFF_FF00, 32'h3333_4444, 1'b1, SH_ROR, 8'h00);
    issue_reg(2'd1, 32'h1234_56FF, 32'h5555_6666, 1'b0, SH_LSR, 8'hFF);
    issue_reg(2'd0, 32'h8000_0040, 32'h7777_8888, 1'b1, SH_LSL, 8'h40);

    // Downstream stall holding a valid output while issue shows a different op.
    issue_imm(2'd0, 5'd9, 32'h9ABC_DEF0, 1'b1, SH_LSL, 8'd9);
    i_stall = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 5'd2, 32'h0BAD_0BAD, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", 64'(o_valid), 64'd1);
      check("stall_amount", 64'(o_amount), 64'd9);
      check("stall_source", 64'(o_source), 64'h9ABC_DEF0);
      check("stall_type", 64'(o_shift_type), 64'(SH_LSL));
      check("stall_carry", 64'(o_carry), 64'd1);
    end
    i_stall = 1'b0;
    i_valid = 1'b0;
    tick();
    check("post_stall_novalid", 64'(o_valid), 64'd0);

    // Reg op stalled in REG_WAIT keeps o_stall high until release.
    drive(1'b1, 1'b1, 2'd0, 5'd0, 32'h2468_ACE0, 32'h0000_0305, 1'b0);
    sb.push_back('{t: SH_LSL, amt: 8'h05, c: 1'b0, src: 32'h2468_ACE0});
    tick();
    i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("regwait_stall_hold", 64'(o_stall), 64'd1);
      check("regwait_stall_novalid", 64'(o_valid), 64'd0);
    end
    i_stall = 1'b0;
    tick();
    check("regwait_release_stall", 64'(o_stall), 64'd0);
    check("regwait_release_valid", 64'(o_valid), 64'd1);
    i_valid = 1'b0;

    // Flush during REG_WAIT drops the bundle; an imm op then flows normally.
    drive(1'b1, 1'b1, 2'd1, 5'd0, 32'hDDDD_EEEE, 32'h0000_0010, 1'b1);
    tick();
    check("clr_pre_stall", 64'(o_stall), 64'd1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
    check("clr_valid", 64'(o_valid), 64'd0);
    check("clr_stall", 64'(o_stall), 64'd0);
    tick();
    check("clr_no_pulse", 64'(o_valid), 64'd0);
    issue_imm(2'd0, 5'd3, 32'h0000_0001, 1'b0, SH_LSL, 8'd3);

    // Flush beats downstream stall.
    drive(1'b1, 1'b1, 2'd2, 5'd0, 32'h1357_9BDF, 32'h0000_0002, 1'b0);
    tick();
    i_stall = 1'b1;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_stall = 1'b0;
    i_valid = 1'b0;
    check("clr_over_stall", 64'(o_stall), 64'd0);
    tick();
    check("clr_over_stall_novalid", 64'(o_valid), 64'd0);

    // Reset in the middle of REG_WAIT.
    drive(1'b1, 1'b1, 2'd2, 5'd0, 32'hFEED_FACE, 32'h0000_0007, 1'b1);
    tick();
    i_reset = 1'b1;
    tick();
    check("rst_mid_valid", 64'(o_valid), 64'd0);
    check("rst_mid_stall", 64'(o_stall), 64'd0);
    check("rst_mid_type", 64'(o_shift_type), 64'(SH_LSL));
    i_reset = 1'b0;
    i_valid = 1'b0;
    tick();
    check("rst_mid_after", 64'(o_valid), 64'd0);

    tick();
    tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
